mult_datapath: RTL and testbench
================================

Name: mult_datapath

Overview:
- Shift-add multiplier datapath and operand/result handshake stage for the mult_ctl sequencer.
- Accepts operand pairs on a valid/ready input and issues a one-cycle start pulse to mult_ctl.
- Performs the add-to-high-half and shift-right operations that mult_ctl commands, and returns multiplier_bit0 to it.
- Captures the 2*WIDTH product on mult_ctl's done and holds it on a valid/ready output until consumed.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. mult_ctl iterates 32 times, so only 32 is supported in the integrated design.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- multiplicand  input  WIDTH  operand A
- multiplier  input  WIDTH  operand B
- start  output  1  one-cycle pulse to mult_ctl
- multiplier_bit0  output  1  product register bit 0, to mult_ctl
- prod_reg_ld_high  input  1  from mult_ctl: add multiplicand into high half
- prod_reg_shift_rt  input  1  from mult_ctl: shift product right by one
- done  input  1  from mult_ctl: final shift this cycle
- out_valid  output  1  product available
- out_ready  input  1  consumer takes product
- product  output  2*WIDTH  result

Behaviour:
- Reset values: all registers clear (mcand, prod, carry, result all 0). State = S_IDLE, in_ready=1, start=0, out_valid=0, product=0. Reset applied mid-operation aborts the operation; no result is produced.
- State S_IDLE: in_ready=1.
  - On in_valid: latch mcand=multiplicand, prod={0,multiplier}, carry=0, go to S_START.
- State S_START: start=1 for exactly one cycle; in_ready=0; go to S_RUN.
  - prod_reg_ld_high is ignored in this cycle. mult_ctl asserts it combinationally alongside start, and honouring it would corrupt the product.
- State S_RUN: in_ready=0.
  - ld_high=1: {carry, prod_hi} = prod_hi + mcand, full WIDTH+1 result.
  - shift_rt=1: prod = {carry, prod[2W-1:1]}, carry=0.
  - ld_high and shift_rt both 1: illegal. Shift has priority; assertion fires in simulation.
  - done=1 (always together with shift_rt): perform the shift, load result with the shifted value, go to S_HOLD.
- State S_HOLD: out_valid=1, product=result, in_ready=0.
  - On out_ready: out_valid falls the next cycle; go to S_IDLE.
  - product retains its value after the handshake.
- multiplier_bit0 = prod[0], registered value, valid in every state.
- Control inputs asserted outside S_RUN are ignored.
- Latency from accept to out_valid: 1 + 1 + sum over 32 iterations of (2 + multiplier bit). Range 66 to 98 cycles.
- Input stalls are not queued: in_valid outside S_IDLE sees in_ready=0.

Optional Feature:
- Macro MULT_DP_OVF_EN.
- Defined: extra output port ovf (1 bit).
  - ovf = OR of product[2W-1:W], registered with result.
  - Means the product does not fit in WIDTH bits.
  - Reset value 0; valid while out_valid.
- Undefined: port absent; no extra logic.

Decomposition:
- Package mult_pkg holds:
  - typedef mult_dp_state_e {S_IDLE, S_START, S_RUN, S_HOLD}, 2 bits
  - localparam MULT_ITER = 32
  - typedefs for the operand and product widths
- Natural sub-module mult_prod_reg: the 2W-bit product register with carry bit and its add/shift/load controls.
- Handshake FSM and result register stay in mult_datapath.
- Integration test top connects mult_datapath to mult_ctl.

Test Plan:
- 3 * 5 with out_ready=1 -> single out_valid pulse, product=64'h0F, accept-to-valid latency 66+2=68.
- 32'hFFFFFFFF * 32'hFFFFFFFF -> product=64'hFFFFFFFE00000001; carry path exercised every iteration; ovf=1 when MULT_DP_OVF_EN is defined.
- 0 * 32'h12345678 -> product=0, latency 66; ovf=0.
- Hold out_ready=0 for 10 cycles after out_valid -> product stable, in_ready=0, in_valid ignored. Release -> back to S_IDLE, next operands accepted.
- Assert reset 20 cycles into an operation, then run 7*6 -> no result from the aborted operation; product=42; all outputs at reset values during reset.
- Hold in_valid high across back-to-back operations (2*2 then 9*9) -> exactly two accepts, products 4 and 81 in order.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier datapath.
package mult_pkg;

  localparam int MULT_ITER = 32;
  localparam int MULT_W    = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_HOLD  = 2'd3
  } mult_dp_state_e;

  typedef logic [MULT_W-1:0]   mult_operand_t;
  typedef logic [2*MULT_W-1:0] mult_product_t;

endpackage

// File: rtl/mult_prod_reg.sv
// Product register for the shift-add multiplier: {carry, prod} with load,
// add-into-high-half and shift-right operations.
module mult_prod_reg
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mplier,
  input  logic                 i_add,
  input  logic                 i_shift,
  output logic [2*WIDTH-1:0]   o_prod,
  output logic [2*WIDTH-1:0]   o_shifted
);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_carry;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_shifted;

  // The carry out of the add becomes the MSB on the following shift.
  assign w_sum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
  assign w_shifted = {r_carry, r_prod[2*WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_carry <= 1'b0;
    end else if (i_load) begin
      r_mcand <= i_mcand;
      r_prod  <= {{WIDTH{1'b0}}, i_mplier};
      r_carry <= 1'b0;
    end else if (i_shift) begin
      r_prod  <= w_shifted;
      r_carry <= 1'b0;
    end else if (i_add) begin
      {r_carry, r_prod[2*WIDTH-1:WIDTH]} <= w_sum;
    end
  end

  assign o_prod    = r_prod;
  assign o_shifted = w_shifted;

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath with operand/result valid-ready handshakes.
// Define MULT_DP_OVF_EN to add the ovf output (product exceeds WIDTH bits).
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 start,
  output logic                 multiplier_bit0,
  input  logic                 prod_reg_ld_high,
  input  logic                 prod_reg_shift_rt,
  input  logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
`ifdef MULT_DP_OVF_EN
  ,
  output logic                 ovf
`endif
);

  mult_dp_state_e     r_state;
  logic               r_in_ready;
  logic               r_start;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_result;
  logic               w_load;
  logic               w_run;
  logic               w_shift;
  logic               w_add;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_shifted;

  // Sequencer commands are honoured only in S_RUN; shift wins over add.
  assign w_load  = (r_state == S_IDLE) && in_valid;
  assign w_run   = (r_state == S_RUN);
  assign w_shift = w_run && prod_reg_shift_rt;
  assign w_add   = w_run && prod_reg_ld_high && !prod_reg_shift_rt;

  mult_prod_reg #(.WIDTH(WIDTH)) u_prod_reg (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_mcand   (multiplicand),
    .i_mplier  (multiplier),
    .i_add     (w_add),
    .i_shift   (w_shift),
    .o_prod    (w_prod),
    .o_shifted (w_shifted)
  );

`ifdef MULT_DP_OVF_EN
  logic r_ovf;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_start     <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
`ifdef MULT_DP_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= S_START;
            r_in_ready <= 1'b0;
            r_start    <= 1'b1;
          end
        end
        S_START: begin
          r_start <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_shift && done) begin
            r_result    <= w_shifted;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
`ifdef MULT_DP_OVF_EN
            r_ovf       <= |w_shifted[2*WIDTH-1:WIDTH];
`endif
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready        = r_in_ready;
  assign start           = r_start;
  assign out_valid       = r_out_valid;
  assign product         = r_result;
  assign multiplier_bit0 = w_prod[0];
`ifdef MULT_DP_OVF_EN
  assign ovf             = r_ovf;
`endif

  a_no_add_and_shift: assert property (@(posedge clk) disable iff (reset)
    !(w_run && prod_reg_ld_high && prod_reg_shift_rt));

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: emulates the mult_ctl sequencer and checks
// products against plain multiplication and timing against the bit count.
`timescale 1ns/1ps
module tb_mult_datapath;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        start;
  logic        multiplier_bit0;
  logic        prod_reg_ld_high;
  logic        prod_reg_shift_rt;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
`ifdef MULT_DP_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  mult_datapath #(.WIDTH(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .multiplicand      (multiplicand),
    .multiplier        (multiplier),
    .start             (start),
    .multiplier_bit0   (multiplier_bit0),
    .prod_reg_ld_high  (prod_reg_ld_high),
    .prod_reg_shift_rt (prod_reg_shift_rt),
    .done              (done),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .product           (product)
`ifdef MULT_DP_OVF_EN
    ,
    .ovf               (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (!reset && in_valid && in_ready) acc_cnt++;

  // mult_ctl stand-in: after start, one idle cycle, then per iteration a test
  // cycle, an add cycle when bit0 is set, and a shift cycle (done on the last).
  typedef enum {P_IDLE1, P_TEST, P_ADD, P_SHIFT} ph_e;
  bit  busy = 0;
  ph_e ph = P_IDLE1;
  int  iter = 0;

  always @(negedge clk) begin
    if (reset) begin
      busy = 0;
      prod_reg_ld_high = 0; prod_reg_shift_rt = 0; done = 0;
    end else if (!busy) begin
      // Outside S_RUN the commands are noise that must be ignored.
      prod_reg_ld_high  = 1'($urandom_range(0, 1));
      prod_reg_shift_rt = 1'($urandom_range(0, 1));
      done              = 1'($urandom_range(0, 1));
      if (start) begin
        busy = 1; ph = P_IDLE1;
        done = 0; prod_reg_shift_rt = 0; prod_reg_ld_high = 1;
      end
    end else begin
      prod_reg_ld_high = 0; prod_reg_shift_rt = 0; done = 0;
      case (ph)
        P_IDLE1: begin ph = P_TEST; iter = 0; end
        P_TEST:  ph = multiplier_bit0 ? P_ADD : P_SHIFT;
        P_ADD:   begin prod_reg_ld_high = 1; ph = P_SHIFT; end
        P_SHIFT: begin
          prod_reg_shift_rt = 1;
          done = (iter == 31);
          iter++;
          if (iter == 32) busy = 0; else ph = P_TEST;
        end
      endcase
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int ready_delay, input string name);
    logic [63:0] exp_p;
    int exp_lat, lat;
    exp_p   = 64'(a) * 64'(b);
    exp_lat = 66 + $countones(b);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    in_valid = 1; multiplicand = a; multiplier = b; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (product !== exp_p) begin
      errors++; $display("FAIL %s_product: got %h want %h", name, product, exp_p);
    end
`ifdef MULT_DP_OVF_EN
    checks++;
    if (ovf !== (|exp_p[63:32])) begin
      errors++; $display("FAIL %s_ovf: got %b want %b", name, ovf, |exp_p[63:32]);
    end
`endif
    repeat (ready_delay) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || product !== exp_p) begin
      errors++; $display("FAIL %s_hold: got valid=%b %h want valid=1 %h", name, out_valid, product, exp_p);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== exp_p) begin
      errors++;
      $display("FAIL %s_consume: got valid=%b ready=%b %h want valid=0 ready=1 %h",
               name, out_valid, in_ready, product, exp_p);
    end
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; out_ready = 0; multiplicand = 0; multiplier = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, start, out_valid, multiplier_bit0} !== 4'b1000 || product !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b st=%b vld=%b b0=%b p=%h want 1 0 0 0 0",
               in_ready, start, out_valid, multiplier_bit0, product);
    end
    reset = 0;
  endtask

  task automatic test_directed();
    run_op(32'd3, 32'd5, 0, "mul_3x5");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mul_max");
    run_op(32'd0, 32'h12345678, 0, "mul_zero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++)
      run_op($urandom, $urandom, $urandom_range(0, 3), $sformatf("rand%0d", i));
  endtask

  task automatic test_stall();
    logic [63:0] held;
    int acc0;
    run_op(32'd6, 32'd7, 0, "pre_stall");
    @(negedge clk);
    in_valid = 1; multiplicand = 32'hABCD; multiplier = 32'h1234; out_ready = 0;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 200 && out_valid !== 1'b1; i++) @(negedge clk);
    held = product;
    acc0 = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; multiplicand = $urandom; multiplier = $urandom;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 64'h0C374FA4) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b ready=%b %h want valid=1 ready=0 %h",
                 out_valid, in_ready, product, 64'h0C374FA4);
      end
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== held || acc_cnt !== acc0) begin
      errors++;
      $display("FAIL stall_release: got valid=%b ready=%b accepts=%0d want 0 1 %0d",
               out_valid, in_ready, acc_cnt, acc0);
    end
    run_op(32'd11, 32'd13, 1, "post_stall");
  endtask

  task automatic test_reset_abort();
    bit seen;
    @(negedge clk);
    in_valid = 1; multiplicand = 32'h00FF00FF; multiplier = 32'h0F0F0F0F;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    repeat (19) @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if ({in_ready, start, out_valid, multiplier_bit0} !== 4'b1000 || product !== 64'h0) begin
      errors++;
      $display("FAIL abort_reset_vals: got rdy=%b st=%b vld=%b b0=%b p=%h want 1 0 0 0 0",
               in_ready, start, out_valid, multiplier_bit0, product);
    end
    repeat (3) @(negedge clk);
    reset = 0;
    seen = 0;
    repeat (120) begin @(negedge clk); if (out_valid === 1'b1) seen = 1; end
    checks++;
    if (seen) begin
      errors++; $display("FAIL abort_no_result: got out_valid=1 want 0");
    end
    run_op(32'd7, 32'd6, 0, "after_abort");
  endtask

  task automatic test_back_to_back();
    int acc0, n;
    logic [63:0] got[2];
    acc0 = acc_cnt;
    @(negedge clk);
    in_valid = 1; multiplicand = 2; multiplier = 2; out_ready = 1;
    n = 0;
    for (int c = 0; c < 500 && n < 2; c++) begin
      @(negedge clk);
      if (acc_cnt - acc0 == 1) begin multiplicand = 9; multiplier = 9; end
      if (acc_cnt - acc0 >= 2) in_valid = 0;
      if (out_valid === 1'b1) begin got[n] = product; n++; end
    end
    in_valid = 0;
    repeat (5) @(negedge clk);
    out_ready = 0;
    checks++;
    if (n !== 2 || got[0] !== 64'd4 || got[1] !== 64'd81) begin
      errors++; $display("FAIL b2b_products: got n=%0d %0d %0d want 2 4 81", n, got[0], got[1]);
    end
    checks++;
    if (acc_cnt - acc0 !== 2) begin
      errors++; $display("FAIL b2b_accepts: got %0d want 2", acc_cnt - acc0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
